// File: rtl/ram_queue_arbiter_if.sv
// Handshake and RAM-pin bundle between ram_queue_arbiter and its environment.
// slave is the arbiter side; master is the producers/consumer/RAM side.
interface ram_queue_arbiter_if #(
    parameter int WIDTH  = 46,
    parameter int ADDR_W = 4
);
    logic              flush;
    logic              enq0_valid;
    logic              enq0_ready;
    logic [WIDTH-1:0]  enq0_bits;
    logic              enq1_valid;
    logic              enq1_ready;
    logic [WIDTH-1:0]  enq1_bits;
    logic              deq_valid;
    logic              deq_ready;
    logic [WIDTH-1:0]  deq_bits;
    logic [ADDR_W:0]   count;
    logic [ADDR_W-1:0] ram_R0_addr;
    logic              ram_R0_en;
    logic [WIDTH-1:0]  ram_R0_data;
    logic [ADDR_W-1:0] ram_W0_addr;
    logic              ram_W0_en;
    logic [WIDTH-1:0]  ram_W0_data;

    modport slave (
        input  flush, enq0_valid, enq0_bits, enq1_valid, enq1_bits, deq_ready, ram_R0_data,
        output enq0_ready, enq1_ready, deq_valid, deq_bits, count,
               ram_R0_addr, ram_R0_en, ram_W0_addr, ram_W0_en, ram_W0_data
    );

    modport master (
        output flush, enq0_valid, enq0_bits, enq1_valid, enq1_bits, deq_ready, ram_R0_data,
        input  enq0_ready, enq1_ready, deq_valid, deq_bits, count,
               ram_R0_addr, ram_R0_en, ram_W0_addr, ram_W0_en, ram_W0_data
    );
endinterface

// File: rtl/ram_queue_arbiter.sv
// Two-requester round-robin enqueue arbiter and FIFO controller over an external
// 1R/1W RAM with combinational read and synchronous write.
module ram_queue_arbiter #(
    parameter int DEPTH  = 16,
    parameter int WIDTH  = 46,
    parameter int ADDR_W = 4
) (
    input  logic               clock,
    input  logic               reset,
    ram_queue_arbiter_if.slave bus
);
    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

    logic [ADDR_W-1:0] head;
    logic [ADDR_W-1:0] tail;
    logic [ADDR_W:0]   cnt;
    logic              prio;

    logic              full;
    logic              empty;
    logic              active;
    logic              enq0_fire;
    logic              enq1_fire;
    logic              enq_fire;
    logic              deq_fire;
    logic [WIDTH-1:0]  wr_data;

    // Readies are gated by reset so nothing is offered while the block is held in reset.
    always_comb begin
        full           = (cnt == FULL_CNT);
        empty          = (cnt == '0);
        active         = reset & ~bus.flush;
        bus.enq0_ready = active & ~full & (~bus.enq1_valid | ~prio);
        bus.enq1_ready = active & ~full & (~bus.enq0_valid |  prio);
        enq0_fire      = bus.enq0_valid & bus.enq0_ready;
        enq1_fire      = bus.enq1_valid & bus.enq1_ready;
        enq_fire       = enq0_fire | enq1_fire;
        bus.deq_valid  = active & ~empty;
        deq_fire       = bus.deq_valid & bus.deq_ready;
        wr_data        = enq1_fire ? bus.enq1_bits : bus.enq0_bits;

        bus.ram_W0_en   = enq_fire;
        bus.ram_W0_addr = tail;
        bus.ram_W0_data = wr_data;
        bus.ram_R0_en   = ~empty;
        bus.ram_R0_addr = head;
        bus.deq_bits    = bus.ram_R0_data;
        bus.count       = cnt;
    end

    // prio only moves on a contended grant, pointing at the requester that lost.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
            prio <= 1'b0;
        end else if (bus.flush) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else begin
            if (enq_fire) tail <= tail + ADDR_W'(1);
            if (deq_fire) head <= head + ADDR_W'(1);
            cnt <= cnt + (ADDR_W+1)'(enq_fire) - (ADDR_W+1)'(deq_fire);
            if (enq_fire && bus.enq0_valid && bus.enq1_valid) prio <= enq0_fire;
        end
    end

    a_cnt_range: assert property (@(posedge clock) disable iff (!reset) cnt <= FULL_CNT);
    a_one_enq: assert property (@(posedge clock) disable iff (!reset) !(enq0_fire && enq1_fire));
    a_deq_nonempty: assert property (@(posedge clock) disable iff (!reset) !(deq_fire && cnt == '0));
endmodule

// File: tb/tb_ram_queue_arbiter.sv
// Directed plus randomized bench for ram_queue_arbiter with a RAM model and
// a queue-based reference model of the shared FIFO.
module tb_ram_queue_arbiter;
    localparam int DEPTH  = 16;
    localparam int WIDTH  = 46;
    localparam int ADDR_W = 4;

    logic clock = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    ram_queue_arbiter_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();

    ram_queue_arbiter #(.DEPTH(DEPTH), .WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // External RAM: synchronous write, combinational read, X when read is disabled.
    logic [WIDTH-1:0] mem [DEPTH];
    always @(posedge clock) begin
        if (bus.ram_W0_en === 1'b1) mem[bus.ram_W0_addr] <= bus.ram_W0_data;
    end
    always_comb bus.ram_R0_data = bus.ram_R0_en ? mem[bus.ram_R0_addr] : 'x;

    // Reference model: contents in order, write slot, and the favoured requester.
    logic [WIDTH-1:0] q [$];
    int mtail = 0;
    bit mprio = 1'b0;
    bit last_e0f = 1'b0;
    bit last_e1f = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_cycle();
        bit live, full, e0r, e1r, dv, e0f, e1f, df;
        int mhead;
        live  = (reset === 1'b1);
        full  = (q.size() == DEPTH);
        e0r   = live && !full && !bus.flush && (!bus.enq1_valid || !mprio);
        e1r   = live && !full && !bus.flush && (!bus.enq0_valid || mprio);
        dv    = live && (q.size() != 0) && !bus.flush;
        e0f   = e0r && bus.enq0_valid;
        e1f   = e1r && bus.enq1_valid;
        df    = dv && bus.deq_ready;
        mhead = (mtail - q.size() + DEPTH) % DEPTH;

        chk("count", bus.count, q.size());
        chk("enq0_ready", bus.enq0_ready, e0r);
        chk("enq1_ready", bus.enq1_ready, e1r);
        chk("deq_valid", bus.deq_valid, dv);
        if (dv) chk("deq_bits", bus.deq_bits, q[0]);
        chk("ram_R0_en", bus.ram_R0_en, q.size() != 0);
        if (q.size() != 0) chk("ram_R0_addr", bus.ram_R0_addr, mhead);
        chk("ram_W0_en", bus.ram_W0_en, e0f || e1f);
        if (e0f || e1f) begin
            chk("ram_W0_addr", bus.ram_W0_addr, mtail);
            chk("ram_W0_data", bus.ram_W0_data, e0f ? bus.enq0_bits : bus.enq1_bits);
        end

        if (!live) begin
            q.delete();
            mtail = 0;
            mprio = 1'b0;
        end else if (bus.flush) begin
            q.delete();
            mtail = 0;
        end else begin
            if (df) void'(q.pop_front());
            if (e0f) q.push_back(bus.enq0_bits);
            if (e1f) q.push_back(bus.enq1_bits);
            if (e0f || e1f) mtail = (mtail + 1) % DEPTH;
            if ((e0f || e1f) && bus.enq0_valid && bus.enq1_valid) mprio = e0f;
        end
        last_e0f = e0f;
        last_e1f = e1f;
    endtask

    task automatic tick();
        #3;
        model_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        bus.flush      = 1'b0;
        bus.enq0_valid = 1'b0;
        bus.enq1_valid = 1'b0;
        bus.deq_ready  = 1'b0;
    endtask

    task automatic drain();
        idle_inputs();
        bus.deq_ready = 1'b1;
        for (int i = 0; i < 40 && q.size() > 0; i++) tick();
        if (q.size() != 0) chk("drain_timeout", q.size(), 0);
        bus.deq_ready = 1'b0;
    endtask

    initial begin
        logic [WIDTH-1:0] t2_exp [4];
        int a_idx;
        int b_idx;

        reset = 1'b0;
        idle_inputs();
        bus.enq0_bits = '0;
        bus.enq1_bits = '0;
        @(posedge clock);
        #1;

        // Held in reset with requests pending: nothing offered, nothing written.
        bus.enq0_valid = 1'b1;
        bus.enq1_valid = 1'b1;
        tick();
        chk("rst_count", bus.count, 0);
        chk("rst_deq_valid", bus.deq_valid, 0);
        chk("rst_enq0_ready", bus.enq0_ready, 0);
        chk("rst_W0_en", bus.ram_W0_en, 0);
        idle_inputs();
        reset = 1'b1;

        // Three single-requester writes, consumer stalled.
        bus.enq0_valid = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            bus.enq0_bits = WIDTH'(i);
            #2 chk("t1_W0_addr", bus.ram_W0_addr, i - 1);
            tick();
            chk("t1_deq_valid", bus.deq_valid, 1);
        end
        bus.enq0_valid = 1'b0;
        chk("t1_count", bus.count, 3);
        chk("t1_deq_bits", bus.deq_bits, 'h1);
        tick();
        drain();

        // Contention: grants alternate starting with requester 0.
        a_idx = 0;
        b_idx = 0;
        bus.enq0_valid = 1'b1;
        bus.enq1_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.enq0_bits = WIDTH'('hA0 + a_idx);
            bus.enq1_bits = WIDTH'('hB0 + b_idx);
            #2 chk("t2_grant0", bus.enq0_ready, (i % 2) == 0);
            tick();
            if (last_e0f) a_idx++;
            if (last_e1f) b_idx++;
        end
        idle_inputs();
        t2_exp[0] = 'hA0;
        t2_exp[1] = 'hB0;
        t2_exp[2] = 'hA1;
        t2_exp[3] = 'hB1;
        bus.deq_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #2 chk("t2_order", bus.deq_bits, t2_exp[i]);
            tick();
        end
        drain();

        // Full boundary: a dequeue while full does not admit an enqueue that cycle.
        bus.enq0_valid = 1'b1;
        for (int i = 0; i < 20 && q.size() < DEPTH; i++) begin
            bus.enq0_bits = WIDTH'({$urandom(), $urandom()});
            tick();
        end
        bus.enq1_valid = 1'b1;
        #2 chk("t3_count_full", bus.count, 16);
        chk("t3_enq0_ready", bus.enq0_ready, 0);
        chk("t3_enq1_ready", bus.enq1_ready, 0);
        bus.enq1_valid = 1'b0;
        bus.deq_ready = 1'b1;
        tick();
        bus.deq_ready = 1'b0;
        #2 chk("t3_count_freed", bus.count, 15);
        chk("t3_enq0_ready_next", bus.enq0_ready, 1);
        tick();
        chk("t3_count_refull", bus.count, 16);
        drain();

        // Streaming 40 entries through: pointers wrap twice, occupancy stays at most 1.
        bus.enq0_valid = 1'b1;
        bus.deq_ready  = 1'b1;
        for (int i = 0; i < 40; i++) begin
            bus.enq0_bits = WIDTH'('h1000 + i);
            tick();
            chk("t4_count_le1", bus.count <= 1, 1);
        end
        drain();

        // Flush with a pending enqueue and dequeue: neither fires.
        bus.enq0_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.enq0_bits = WIDTH'('h50 + i);
            tick();
        end
        bus.flush     = 1'b1;
        bus.deq_ready = 1'b1;
        #2 chk("t5_enq0_ready", bus.enq0_ready, 0);
        chk("t5_deq_valid_flush", bus.deq_valid, 0);
        chk("t5_W0_en", bus.ram_W0_en, 0);
        tick();
        idle_inputs();
        #2 chk("t5_count", bus.count, 0);
        chk("t5_deq_valid", bus.deq_valid, 0);
        tick();

        // Asynchronous reset in the middle of a stream at occupancy 7.
        bus.enq0_valid = 1'b1;
        for (int i = 0; i < 7; i++) begin
            bus.enq0_bits = WIDTH'('h70 + i);
            tick();
        end
        bus.deq_ready = 1'b1;
        bus.enq0_bits = WIDTH'('h77);
        tick();
        chk("t6_count_pre", bus.count, 7);
        #2 reset = 1'b0;
        #1 chk("t6_count_async", bus.count, 0);
        chk("t6_deq_valid_async", bus.deq_valid, 0);
        chk("t6_enq0_ready_async", bus.enq0_ready, 0);
        chk("t6_W0_en_async", bus.ram_W0_en, 0);
        q.delete();
        mtail = 0;
        mprio = 1'b0;
        tick();
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus.enq0_bits = WIDTH'('h90 + i);
            tick();
        end
        drain();

        // Randomized traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            bus.enq0_valid = 1'($urandom_range(0, 1));
            bus.enq1_valid = 1'($urandom_range(0, 1));
            bus.deq_ready  = ($urandom_range(0, 3) != 0) ? 1'b0 : 1'b1;
            if (i >= 200) bus.deq_ready = 1'($urandom_range(0, 1));
            bus.flush      = ($urandom_range(0, 39) == 0);
            bus.enq0_bits  = WIDTH'({$urandom(), $urandom()});
            bus.enq1_bits  = WIDTH'({$urandom(), $urandom()});
            tick();
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
